instruction_memory_loader: RTL and testbench

//  Parametrised instruction memory for the processor fetch stage. The program
//  is streamed in at run time over a valid/ready load port, not hard-coded.

---
 rtl/instruction_memory_loader.sv | 182 ++++++++++++++++++
 tb/tb_instruction_memory_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loader.sv
// Run-time loadable instruction memory with registered fetch port.
// Optional parity protection: define INSTR_MEM_PARITY_EN.
module instruction_memory_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter logic [DATA_W-1:0] HALT_WORD =
    DATA_W'(32'h6000_0000)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_done,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_fault,
  output logic              busy,
`ifdef INSTR_MEM_PARITY_EN
  output logic              parity_err,
`endif
  output logic [ADDR_W:0]   prog_len
);

  localparam int LW = ADDR_W + 1;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    READY
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef INSTR_MEM_PARITY_EN
  logic              par [DEPTH];
  logic              parity_err_q, parity_err_d;
  logic              rd_par_bad;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              addr_fault_q, addr_fault_d;
  logic              load_ready_q, load_ready_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              we;
  logic [ADDR_W:0]   cnt;
  logic              fetch_hit;
  logic [DATA_W-1:0] rd_word;

  assign accept    = load_valid & load_ready_q;
  assign cnt       = wptr_q + LW'(accept);
  assign fetch_hit = {1'b0, fetch_addr} < prog_len_q;
  assign rd_word   = mem[fetch_addr];
`ifdef INSTR_MEM_PARITY_EN
  assign rd_par_bad = (^rd_word) != par[fetch_addr];
`endif

  // Next-state: load sequencing and fetch result selection
  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    prog_len_d    = prog_len_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    addr_fault_d  = 1'b0;
    load_ready_d  = load_ready_q;
    busy_d        = busy_q;
    we            = 1'b0;
`ifdef INSTR_MEM_PARITY_EN
    parity_err_d  = 1'b0;
`endif
    unique case (state_q)
      LOAD: begin
        if (load_start) begin
          // restart: earlier words are dropped
          wptr_d       = '0;
          load_ready_d = 1'b1;
          busy_d       = 1'b1;
        end else begin
          we = accept;
          if (accept && wptr_q == LW'(DEPTH - 1)) begin
            state_d      = READY;
            prog_len_d   = LW'(DEPTH);
            wptr_d       = '0;
            load_ready_d = 1'b0;
            busy_d       = 1'b0;
          end else if (load_done) begin
            state_d      = (cnt != '0) ? READY : EMPTY;
            prog_len_d   = cnt;
            wptr_d       = '0;
            load_ready_d = 1'b0;
            busy_d       = 1'b0;
          end else begin
            wptr_d = cnt;
          end
        end
      end
      default: begin
        if (load_start) begin
          // load wins over a simultaneous fetch
          state_d      = LOAD;
          wptr_d       = '0;
          load_ready_d = 1'b1;
          busy_d       = 1'b1;
        end else if (fetch_en) begin
          instr_valid_d = 1'b1;
          if (fetch_hit) begin
            instr_d = rd_word;
`ifdef INSTR_MEM_PARITY_EN
            if (rd_par_bad) begin
              instr_d      = HALT_WORD;
              parity_err_d = 1'b1;
            end
`endif
          end else begin
            instr_d      = HALT_WORD;
            addr_fault_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= EMPTY;
      wptr_q        <= '0;
      prog_len_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      addr_fault_q  <= 1'b0;
      load_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      prog_len_q    <= prog_len_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      addr_fault_q  <= addr_fault_d;
      load_ready_q  <= load_ready_d;
      busy_q        <= busy_d;
`ifdef INSTR_MEM_PARITY_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  // Storage array write port, not reset
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wptr_q[ADDR_W-1:0]] <= load_data;
`ifdef INSTR_MEM_PARITY_EN
      par[wptr_q[ADDR_W-1:0]] <= ^load_data;
`endif
    end
  end

  assign load_ready  = load_ready_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign addr_fault  = addr_fault_q;
  assign busy        = busy_q;
  assign prog_len    = prog_len_q;
`ifdef INSTR_MEM_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader (DEPTH=4).
// Fetch results are checked through an expected-result queue.
module tb_instruction_memory_loader;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int DP = 4;
  localparam logic [DW-1:0] HALT = 32'h6000_0000;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic          fetch_en;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          addr_fault;
  logic          busy;
  logic [AW:0]   prog_len;
`ifdef INSTR_MEM_PARITY_EN
  logic          parity_err;
`endif

  typedef struct {
    logic [DW-1:0] instr;
    logic          valid;
    logic          fault;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  instruction_memory_loader #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP),
    .HALT_WORD(HALT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .load_done(load_done),
    .fetch_en(fetch_en),
    .fetch_addr(fetch_addr),
    .instr(instr),
    .instr_valid(instr_valid),
    .addr_fault(addr_fault),
    .busy(busy),
`ifdef INSTR_MEM_PARITY_EN
    .parity_err(parity_err),
`endif
    .prog_len(prog_len)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic lw(input logic v,
                    input logic [DW-1:0] d,
                    input logic done);
    load_valid = v;
    load_data  = d;
    load_done  = done;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic fetch(input string tag,
                       input logic en,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] ei,
                       input logic ev,
                       input logic ef);
    exp_t e;
    fetch_en   = en;
    fetch_addr = a;
    e.instr = ei;
    e.valid = ev;
    e.fault = ef;
    sb.push_back(e);
    tick();
    fetch_en = 1'b0;
    e = sb.pop_front();
    chk({tag, ".instr"}, 64'(instr), 64'(e.instr));
    chk({tag, ".valid"}, 64'(instr_valid), 64'(e.valid));
    chk({tag, ".fault"}, 64'(addr_fault), 64'(e.fault));
  endtask

  logic [DW-1:0] wa, wb, wc, d0, d1, x, y;
  logic [DW-1:0] w [6];

  initial begin
    wa = 32'h0000_0013;
    wb = 32'h0010_0093;
    wc = 32'h0020_0113;
    d0 = 32'h1234_5678;
    d1 = 32'h9abc_def0;
    x  = 32'hcafe_f00d;
    y  = 32'hdead_beef;
    for (int i = 0; i < 6; i++) w[i] = 32'ha000_0000 + i;

    reset_n    = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_done  = 1'b0;
    fetch_en   = 1'b0;
    fetch_addr = '0;
    #12;
    chk("rst.instr", 64'(instr), 64'(0));
    chk("rst.valid", 64'(instr_valid), 64'(0));
    chk("rst.fault", 64'(addr_fault), 64'(0));
    chk("rst.ready", 64'(load_ready), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.plen", 64'(prog_len), 64'(0));
`ifdef INSTR_MEM_PARITY_EN
    chk("rst.perr", 64'(parity_err), 64'(0));
`endif
    @(negedge clock);
    reset_n = 1'b1;

    // empty memory: every fetch faults
    fetch("t1.f0", 1'b1, 3'd0, HALT, 1'b1, 1'b1);
    fetch("t1.idle", 1'b0, 3'd0, HALT, 1'b0, 1'b0);

    // three-word load, done with the last word
    start_load();
    chk("t2.busy", 64'(busy), 64'(1));
    chk("t2.ready", 64'(load_ready), 64'(1));
    lw(1'b1, wa, 1'b0);
    lw(1'b1, wb, 1'b0);
    lw(1'b1, wc, 1'b1);
    chk("t2.plen", 64'(prog_len), 64'(3));
    chk("t2.busy0", 64'(busy), 64'(0));
    chk("t2.ready0", 64'(load_ready), 64'(0));
    fetch("t2.f0", 1'b1, 3'd0, wa, 1'b1, 1'b0);
    fetch("t2.f1", 1'b1, 3'd1, wb, 1'b1, 1'b0);
    fetch("t2.f2", 1'b1, 3'd2, wc, 1'b1, 1'b0);
    fetch("t2.f3", 1'b1, 3'd3, HALT, 1'b1, 1'b1);
    fetch("t2.idle", 1'b0, 3'd0, HALT, 1'b0, 1'b0);
`ifdef INSTR_MEM_PARITY_EN
    chk("t2.perr", 64'(parity_err), 64'(0));
`endif

    // gap cycle and load_done alone
    start_load();
    lw(1'b1, d0, 1'b0);
    fetch("t3.gap", 1'b1, 3'd0, HALT, 1'b0, 1'b0);
    lw(1'b1, d1, 1'b0);
    lw(1'b0, 32'hffff_ffff, 1'b1);
    chk("t3.plen", 64'(prog_len), 64'(2));
    chk("t3.busy", 64'(busy), 64'(0));
    fetch("t3.f1", 1'b1, 3'd1, d1, 1'b1, 1'b0);
    fetch("t3.f2", 1'b1, 3'd2, HALT, 1'b1, 1'b1);
    fetch("t3.f0", 1'b1, 3'd0, d0, 1'b1, 1'b0);

    // zero-word load returns to EMPTY
    start_load();
    lw(1'b0, 32'h0, 1'b1);
    chk("t3z.plen", 64'(prog_len), 64'(0));
    chk("t3z.busy", 64'(busy), 64'(0));
    fetch("t3z.f0", 1'b1, 3'd0, HALT, 1'b1, 1'b1);

    // overflow: six words into four slots
    start_load();
    for (int i = 0; i < 6; i++) begin
      lw(1'b1, w[i], 1'b0);
      if (i == 2)
        chk("t4.ready3", 64'(load_ready), 64'(1));
      if (i >= 3) begin
        chk($sformatf("t4.ready%0d", i + 1),
            64'(load_ready), 64'(0));
        chk($sformatf("t4.plen%0d", i + 1),
            64'(prog_len), 64'(4));
      end
    end
    chk("t4.busy", 64'(busy), 64'(0));
    fetch("t4.f0", 1'b1, 3'd0, w[0], 1'b1, 1'b0);
    fetch("t4.f3", 1'b1, 3'd3, w[3], 1'b1, 1'b0);
    fetch("t4.f4", 1'b1, 3'd4, HALT, 1'b1, 1'b1);
    fetch("t4.f7", 1'b1, 3'd7, HALT, 1'b1, 1'b1);

    // load_start beats a simultaneous fetch
    load_start = 1'b1;
    fetch("t5.lwin", 1'b1, 3'd0, HALT, 1'b0, 1'b0);
    load_start = 1'b0;
    chk("t5.busy", 64'(busy), 64'(1));
    lw(1'b1, d0, 1'b0);
    lw(1'b1, d1, 1'b0);
    start_load();
    chk("t5.rbusy", 64'(busy), 64'(1));
    chk("t5.rready", 64'(load_ready), 64'(1));
    lw(1'b1, x, 1'b1);
    chk("t5.plen", 64'(prog_len), 64'(1));
    fetch("t5.f0", 1'b1, 3'd0, x, 1'b1, 1'b0);
    fetch("t5.f1", 1'b1, 3'd1, HALT, 1'b1, 1'b1);

    // reset in the middle of a load
    start_load();
    lw(1'b1, y, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t5r.plen", 64'(prog_len), 64'(0));
    chk("t5r.busy", 64'(busy), 64'(0));
    chk("t5r.ready", 64'(load_ready), 64'(0));
    chk("t5r.instr", 64'(instr), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    fetch("t5r.f0", 1'b1, 3'd0, HALT, 1'b1, 1'b1);

`ifdef INSTR_MEM_PARITY_EN
    // corrupt a stored word and expect a parity error
    start_load();
    lw(1'b1, x, 1'b1);
    force dut.mem[0] = x ^ 32'h1;
    fetch("t6.f0", 1'b1, 3'd0, HALT, 1'b1, 1'b0);
    chk("t6.perr", 64'(parity_err), 64'(1));
    release dut.mem[0];
`endif

    chk("end.sbempty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
